// File: rtl/fetch_stage.sv
// Fetch stage: single-outstanding imem port feeding a 2-entry {instr, pc+2} buffer, head shown combinationally.
// Latency >=1 cycle imem response plus one edge to the head; stall holds the head, fetch pauses when buffer+request reach 2.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] pc_inc2,
  output logic        fetch_empty
);
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_pc;
  logic [1:0]  r_count;
  logic        r_outstanding;
  logic        r_discard;
  logic [15:0] r_q_instr [2];
  logic [15:0] r_q_pc    [2];

  logic w_empty;
  logic w_grant;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_slot;

  assign w_empty     = (r_count == 2'd0);
  assign imem_req    = rst & (r_state == ST_RUN) & ~r_outstanding & (r_count < 2'd2) & ~redirect;
  assign imem_addr   = r_pc;
  assign w_grant     = imem_req & imem_gnt;
  assign w_accept    = imem_valid & r_outstanding;
  assign w_push      = w_accept & ~r_discard & ~redirect;
  assign w_pop       = ~stall & ~w_empty & ~redirect;
  // Write slot after an optional same-edge pop: count 0/1/2 with pop 0/1 maps to this parity.
  assign w_slot      = r_count[0] ^ w_pop;

  assign instr       = w_empty ? 16'h0fff : r_q_instr[0];
  assign pc_inc2     = w_empty ? 16'h0000 : r_q_pc[0];
  assign fetch_empty = w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_pc          <= 16'h0000;
      r_count       <= 2'd0;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
    end else if (redirect) begin
      r_state       <= ST_RUN;
      r_pc          <= {redirect_pc[15:1], 1'b0};
      r_count       <= 2'd0;
      // A response still in flight belongs to the old path and must be swallowed when it lands.
      r_outstanding <= r_outstanding & ~w_accept;
      r_discard     <= r_outstanding & ~w_accept;
    end else begin
      if (w_accept) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end else if (w_grant) begin
        r_outstanding <= 1'b1;
        r_pc          <= r_pc + 16'd2;
      end
      if ((r_state == ST_RUN) && halt) begin
        r_state <= ST_HALTED;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // pc already moved past the outstanding request, so it is exactly that request's address + 2.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_q_instr[0] <= r_q_instr[1];
      r_q_pc[0]    <= r_q_pc[1];
    end
    if (w_push) begin
      r_q_instr[w_slot] <= imem_data;
      r_q_pc[w_slot]    <= r_pc;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against an address-stream reference model.
// A behavioural memory answers granted requests after a configurable latency.
module tb_fetch_stage;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] pc_inc2;
  logic        fetch_empty;

  int checks = 0;
  int errors = 0;

  int gnt_pct      = 100;
  int lat_min      = 1;
  int lat_max      = 1;
  bit mem_scramble = 1'b0;
  bit mem_noise    = 1'b0;
  int mem_epoch    = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_valid(imem_valid), .imem_data(imem_data), .instr(instr), .pc_inc2(pc_inc2),
    .fetch_empty(fetch_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] memword(input logic [15:0] a);
    return mem_scramble ? (a ^ 16'h3c5a) : a;
  endfunction

  // Memory: drives gnt/valid 2 units after negedge, samples requests 1 unit before posedge.
  initial begin : memory
    bit          pending;
    logic [15:0] p_addr;
    int          p_lat;
    int          seen_epoch;
    pending = 1'b0; p_addr = '0; p_lat = 0; seen_epoch = 0;
    imem_gnt = 1'b0; imem_valid = 1'b0; imem_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (seen_epoch != mem_epoch) begin
        pending    = 1'b0;
        seen_epoch = mem_epoch;
      end
      imem_gnt = (int'($urandom_range(99)) < gnt_pct);
      if (pending && p_lat == 0) begin
        imem_valid = 1'b1;
        imem_data  = memword(p_addr);
      end else if (!pending && mem_noise && $urandom_range(7) == 0) begin
        imem_valid = 1'b1;
        imem_data  = 16'($urandom);
      end else begin
        imem_valid = 1'b0;
        imem_data  = 16'($urandom);
      end
      #2;
      if (pending) begin
        if (p_lat == 0) pending = 1'b0;
        else p_lat--;
      end
      if (imem_req && imem_gnt) begin
        pending = 1'b1;
        p_addr  = imem_addr;
        p_lat   = int'($urandom_range(lat_max, lat_min)) - 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    mem_epoch++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); #3;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_req: req=%b addr=%h expected req=0 addr=0000", imem_req, imem_addr);
    end
    checks++;
    if (instr !== 16'h0fff || pc_inc2 !== 16'h0000 || fetch_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_out: instr=%h pc_inc2=%h empty=%b expected 0fff 0000 1", instr, pc_inc2, fetch_empty);
    end
    @(negedge clk);
    rst = 1'b1;
    #3;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL first_req: req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_straight();
    gnt_pct = 100; lat_min = 1; lat_max = 1; mem_scramble = 1'b0; mem_noise = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #3;
      checks++;
      if (fetch_empty !== 1'b1) begin
        errors++; $display("FAIL straight_gap[%0d]: empty=%b expected 1", k, fetch_empty);
      end
      @(negedge clk); #3;
      checks++;
      if (fetch_empty !== 1'b0 || instr !== 16'(2 * k) || pc_inc2 !== 16'(2 * k + 2)) begin
        errors++;
        $display("FAIL straight_word[%0d]: instr=%h pc_inc2=%h empty=%b expected %h %h 0",
                 k, instr, pc_inc2, fetch_empty, 16'(2 * k), 16'(2 * k + 2));
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] got[$];
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    stall = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0004) begin
      errors++; $display("FAIL full_req: req=%b pc=%h expected req=0 pc=0004", imem_req, imem_addr);
    end
    checks++;
    if (fetch_empty !== 1'b0 || instr !== 16'h0000 || pc_inc2 !== 16'h0002) begin
      errors++; $display("FAIL full_head: instr=%h pc_inc2=%h empty=%b expected 0000 0002 0", instr, pc_inc2, fetch_empty);
    end
    stall = 1'b0;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      if (!fetch_empty) got.push_back(instr);
      @(negedge clk); #3;
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL full_drain: delivered %0d words expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== 16'(2 * i)) begin
          errors++; $display("FAIL full_order[%0d]: instr=%h expected %h", i, got[i], 16'(2 * i));
        end
      end
    end
  endtask

  task automatic test_redirect();
    bit seen_req;
    bit seen_out;
    seen_req = 1'b0; seen_out = 1'b0;
    gnt_pct = 0; lat_min = 3; lat_max = 3;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    redirect = 1'b0; gnt_pct = 100;
    #3;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      errors++; $display("FAIL redir_grant: req=%b addr=%h expected req=1 addr=0010", imem_req, imem_addr);
    end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0101;
    @(negedge clk);
    redirect = 1'b0;
    #3;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL redir_wait: req=%b expected 0 while stale response pending", imem_req);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #3;
      if (!seen_req && imem_req) begin
        seen_req = 1'b1;
        checks++;
        if (imem_addr !== 16'h0100) begin
          errors++; $display("FAIL redir_addr: addr=%h expected 0100", imem_addr);
        end
      end
      if (!fetch_empty) begin
        seen_out = 1'b1;
        checks++;
        if (instr !== 16'h0100 || pc_inc2 !== 16'h0102) begin
          errors++; $display("FAIL redir_word: instr=%h pc_inc2=%h expected 0100 0102", instr, pc_inc2);
        end
        break;
      end
    end
    checks++;
    if (!seen_req || !seen_out) begin
      errors++; $display("FAIL redir_timeout: req_seen=%b out_seen=%b expected 1 1", seen_req, seen_out);
    end
  endtask

  task automatic test_simul();
    bit seen_out;
    seen_out = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0200;
    #3;
    checks++;
    if (fetch_empty !== 1'b0 || instr !== 16'h0000) begin
      errors++; $display("FAIL simul_pre: instr=%h empty=%b expected 0000 0", instr, fetch_empty);
    end
    @(negedge clk);
    redirect = 1'b0;
    #3;
    checks++;
    if (instr !== 16'h0fff || pc_inc2 !== 16'h0000 || fetch_empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_flush: instr=%h pc_inc2=%h empty=%b expected 0fff 0000 1", instr, pc_inc2, fetch_empty);
    end
    for (int c = 0; c < 10 && !seen_out; c++) begin
      @(negedge clk); #3;
      if (!fetch_empty) begin
        seen_out = 1'b1;
        checks++;
        if (instr !== 16'h0200 || pc_inc2 !== 16'h0202) begin
          errors++; $display("FAIL simul_resume: instr=%h pc_inc2=%h expected 0200 0202", instr, pc_inc2);
        end
      end
    end
    checks++;
    if (!seen_out) begin
      errors++; $display("FAIL simul_timeout: no instruction after redirect, expected 0200");
    end
  endtask

  task automatic test_halt();
    int  req_hits;
    bit  seen_req;
    bit  seen_out;
    req_hits = 0; seen_req = 1'b0; seen_out = 1'b0;
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    stall = 1'b1;
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #3;
      if (imem_req) req_hits++;
      @(negedge clk);
    end
    #3;
    checks++;
    if (req_hits != 0) begin
      errors++; $display("FAIL halt_no_req: req seen %0d cycles expected 0", req_hits);
    end
    checks++;
    if (fetch_empty !== 1'b0 || instr !== 16'h0000) begin
      errors++; $display("FAIL halt_buffered: instr=%h empty=%b expected 0000 0", instr, fetch_empty);
    end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    for (int c = 0; c < 12 && !seen_out; c++) begin
      #3;
      if (!seen_req && imem_req) begin
        seen_req = 1'b1;
        checks++;
        if (imem_addr !== 16'h0040) begin
          errors++; $display("FAIL halt_resume_addr: addr=%h expected 0040", imem_addr);
        end
      end
      if (!fetch_empty) begin
        seen_out = 1'b1;
        checks++;
        if (instr !== 16'h0040 || pc_inc2 !== 16'h0042) begin
          errors++; $display("FAIL halt_resume_word: instr=%h pc_inc2=%h expected 0040 0042", instr, pc_inc2);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!seen_req || !seen_out) begin
      errors++; $display("FAIL halt_timeout: req_seen=%b out_seen=%b expected 1 1", seen_req, seen_out);
    end
  endtask

  task automatic test_wrap_reset();
    int nonempty;
    nonempty = 0;
    gnt_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hffff; stall = 1'b1;
    @(negedge clk);
    redirect = 1'b0; gnt_pct = 100;
    for (int c = 0; c < 10; c++) begin
      #3;
      if (!fetch_empty) break;
      @(negedge clk);
    end
    checks++;
    if (fetch_empty !== 1'b0 || instr !== 16'hfffe || pc_inc2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_word: instr=%h pc_inc2=%h empty=%b expected fffe 0000 0", instr, pc_inc2, fetch_empty);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL wrap_pc: req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
    lat_min = 3; lat_max = 3;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr !== 16'h0fff || pc_inc2 !== 16'h0000 || fetch_empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: req=%b instr=%h pc_inc2=%h empty=%b expected 0 0fff 0000 1",
               imem_req, instr, pc_inc2, fetch_empty);
    end
    gnt_pct = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      if (!fetch_empty) nonempty++;
      @(negedge clk);
    end
    #3;
    checks++;
    if (nonempty != 0) begin
      errors++; $display("FAIL reset_stale_valid: buffered %0d cycles expected 0", nonempty);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset_restart: req=%b addr=%h expected req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  // Reference: decode must see the sequential address stream from 0, restarting at each redirect target.
  task automatic test_random();
    logic [15:0] exp_addr;
    logic [15:0] prev_addr;
    bit          prev_wait;
    int          delivered;
    exp_addr = 16'h0000; prev_addr = 16'h0000; prev_wait = 1'b0; delivered = 0;
    gnt_pct = 70; lat_min = 1; lat_max = 3; mem_scramble = 1'b1; mem_noise = 1'b1;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c > 0) @(negedge clk);
      stall       = ($urandom_range(2) == 0);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = 16'($urandom);
      #3;
      if (prev_wait && !redirect) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL rand_hold[%0d]: req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, prev_addr);
        end
      end
      if (fetch_empty) begin
        checks++;
        if (instr !== 16'h0fff || pc_inc2 !== 16'h0000) begin
          errors++; $display("FAIL rand_bubble[%0d]: instr=%h pc_inc2=%h expected 0fff 0000", c, instr, pc_inc2);
        end
      end else if (!redirect && !stall) begin
        checks++;
        if (instr !== memword(exp_addr) || pc_inc2 !== exp_addr + 16'd2) begin
          errors++;
          $display("FAIL rand_word[%0d]: instr=%h pc_inc2=%h expected %h %h",
                   c, instr, pc_inc2, memword(exp_addr), exp_addr + 16'd2);
        end
        exp_addr = exp_addr + 16'd2;
        delivered++;
      end
      if (redirect) exp_addr = {redirect_pc[15:1], 1'b0};
      prev_wait = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (delivered < 50) begin
      errors++; $display("FAIL rand_progress: delivered %0d expected at least 50", delivered);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    test_reset();
    test_straight();
    test_full();
    test_redirect();
    test_simul();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low; asserting it clears all state immediately.
REQ-003 SHALL have port stall  input  1  downstream decode hold (RAW or MA/EX stall); head entry is not consumed while high.
REQ-004 SHALL have port redirect  input  1  taken branch/jump from memory-access stage.
REQ-005 SHALL have port redirect_pc  input  16  new fetch address; bit 0 forced to 0.
REQ-006 SHALL have port halt  input  1  halt decoded downstream; stops further fetching.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  16  request address, equal to pc.
REQ-009 SHALL have port imem_gnt  input  1  request accepted this cycle when high with imem_req.
REQ-010 SHALL have port imem_valid  input  1  read data valid for the single outstanding request.
REQ-011 SHALL have port imem_data  input  16  returned instruction word.
REQ-012 SHALL have port instr  output  16  instruction to decode; 16'h0fff (NOP) when no entry is available.
REQ-013 SHALL have port pc_inc2  output  16  fetch address of instr plus 2; 16'h0000 when instr is the NOP bubble.
REQ-014 SHALL have port fetch_empty  output  1  high when instr is a bubble.

Function
REQ-015 SHALL hold a 16-bit pc register; pc+2 wraps modulo 2^16 (16'hfffe -> 16'h0000).
REQ-016 SHALL hold a 2-entry FIFO of {instr, pc_inc2}, plus 2-bit count, 1-bit outstanding flag, and 1-bit discard flag.
REQ-017 SHALL implement FSM states RUN and HALTED; reset state is RUN.
REQ-018 SHALL drive imem_req = (state==RUN) & !outstanding & (count < 2) & !redirect.
REQ-019 SHALL, on imem_req & imem_gnt, set outstanding and advance pc by 2 on the same edge.
REQ-020 SHALL hold imem_req and imem_addr stable while imem_gnt is low.
REQ-021 SHALL accept imem_valid only while outstanding is set; imem_valid otherwise is ignored. Response latency is one or more cycles after grant.
REQ-022 SHALL, on accepted imem_valid with discard clear, push {imem_data, request address + 2} and clear outstanding.
REQ-023 SHALL, on accepted imem_valid with discard set, drop the data and clear both outstanding and discard.
REQ-024 SHALL present the FIFO head combinationally on instr/pc_inc2 when count > 0.
REQ-025 SHALL pop the head on a clock edge where !stall & count > 0.
REQ-026 SHALL allow push and pop on the same edge; count is then unchanged, and the new entry becomes visible behind the head.
REQ-027 SHALL give redirect the highest priority. On a redirect edge:
  - FIFO cleared (count=0);
  - pc <= {redirect_pc[15:1],1'b0};
  - state <= RUN;
  - if outstanding and no imem_valid that cycle, discard set;
  - a same-cycle imem_valid is dropped.
REQ-028 SHALL, on halt high in RUN without redirect, enter HALTED. Outstanding responses still complete into the FIFO. No new requests issue.
REQ-029 SHALL leave HALTED only through redirect or reset.
REQ-030 SHALL ignore stall for request issue; fetch continues until the FIFO plus the outstanding request reaches 2.

Reset
REQ-031 SHALL, while rst is low, force:
  - pc=16'h0000, count=0, outstanding=0, discard=0, state=RUN;
  - imem_req=0, instr=16'h0fff, pc_inc2=16'h0000, fetch_empty=1.
REQ-032 SHALL issue its first request with imem_addr=16'h0000 in the first cycle after rst deasserts.
REQ-033 SHALL, on reset asserted mid-request, drop all in-flight state; a later imem_valid is ignored because outstanding=0.

Verification
REQ-034 Straight-line fetch: gnt tied high, 1-cycle valid latency, memory word = address; stall=0 -> instr sequence 0000,0002,0004,... with pc_inc2 = instr+2, one instruction every 2 cycles.
REQ-035 Full buffer: stall=1 for 10 cycles -> exactly 2 entries buffered (addresses 0,2), imem_req low, pc=16'h0004; release stall -> 0000,0002,0004 delivered in order with no loss.
REQ-036 Redirect during outstanding request: grant at 0x0010, redirect to 0x0101 before valid -> response for 0x0010 discarded, next imem_addr=16'h0100, next instr from 0x0100 with pc_inc2=16'h0102.
REQ-037 Simultaneous push/pop and redirect: count=1, imem_valid, !stall and redirect in the same cycle -> count=0, instr=16'h0fff next cycle, fetch_empty=1.
REQ-038 Halt: halt pulse in RUN with request outstanding -> response buffered, no further imem_req; redirect to 0x0040 -> fetch resumes at 0x0040.
REQ-039 Wrap and async reset: redirect to 0xfffe -> pc_inc2=16'h0000; drop rst mid-wait -> outputs reach reset values without a clock edge.
